// File: rtl/iir_ctrl_pkg.sv
// Shared constants and state encoding for the IIR run controller.
// Default memory map, BRAM/datapath latencies and the controller FSM states.
package iir_ctrl_pkg;

    localparam logic [15:0] DEF_COEF_BASE = 16'd0;
    localparam logic [15:0] DEF_IN_BASE   = 16'd2000;
    localparam logic [15:0] DEF_OUT_BASE  = 16'd3000;
    localparam logic [15:0] DEF_NPAIRS    = 16'd150;
    localparam int          DEF_RD_LAT    = 2;
    localparam int          DEF_DP_LAT    = 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        COEF   = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4
    } state_e;

endpackage

// File: rtl/iir_run_ctrl_if.sv
// BRAM read/write port bundle between the run controller and the sample memory.
interface iir_run_ctrl_if;

    logic [15:0] rd_addr;
    logic [15:0] rd_data;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [15:0] wr_data;

    modport master (output rd_addr, wr_en, wr_addr, wr_data, input rd_data);
    modport slave  (input rd_addr, wr_en, wr_addr, wr_data, output rd_data);

endinterface

// File: rtl/iir_vld_pipe.sv
// Valid/tag delay line following each issued read address through BRAM and datapath.
// Taps at stage TAP (read data arrives) and at the last stage (result ready).
module iir_vld_pipe #(
    parameter int DEPTH = 3,
    parameter int TAP   = 1,
    parameter int TAG_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    input  logic [TAG_W-1:0] in_tag,
    output logic             tap_vld,
    output logic [TAG_W-1:0] tap_tag,
    output logic             out_vld
);

    logic [DEPTH-1:0] vld_q;
    logic [TAG_W-1:0] tag_q [DEPTH];

    // Tags carry control meaning too, so the whole line is cleared on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) tag_q[i] <= '0;
        end else begin
            vld_q[0] <= in_vld;
            tag_q[0] <= in_tag;
            for (int i = 1; i < DEPTH; i++) begin
                vld_q[i] <= vld_q[i-1];
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign tap_vld = vld_q[TAP];
    assign tap_tag = tag_q[TAP];
    assign out_vld = vld_q[DEPTH-1];

endmodule

// File: rtl/iir_run_ctrl.sv
// Run controller: loads four coefficients, streams NPAIRS packed sample words through
// the external IIR datapath and writes the packed results back to BRAM.
module iir_run_ctrl
    import iir_ctrl_pkg::*;
#(
    parameter logic [15:0] COEF_BASE = DEF_COEF_BASE,
    parameter logic [15:0] IN_BASE   = DEF_IN_BASE,
    parameter logic [15:0] OUT_BASE  = DEF_OUT_BASE,
    parameter logic [15:0] NPAIRS    = DEF_NPAIRS,
    parameter int          RD_LAT    = DEF_RD_LAT,
    parameter int          DP_LAT    = DEF_DP_LAT
) (
    input  logic                  clk,
    input  logic                  memctl,
    iir_run_ctrl_if.master        bus,
    output logic                  dp_en,
    output logic [7:0]            coef_a,
    output logic [7:0]            coef_b,
    output logic [7:0]            coef_c,
    output logic [7:0]            coef_d,
    output logic [7:0]            x2k,
    output logic [7:0]            x2k1,
    input  logic [7:0]            y2k,
    input  logic [7:0]            y2k1,
    output logic [15:0]           cycles,
    output logic                  done
);

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_e      state;
    logic [2:0]  cidx;
    logic [15:0] rd_cnt;
    logic [15:0] wr_cnt;
    logic        issue_coef;
    logic        issue_data;
    logic        tap_vld;
    logic [2:0]  tap_tag;
    logic        out_vld;
    logic        coef_last;
    logic        wr_fire;

    assign issue_coef = (state == COEF) && (cidx < 3'd4);
    assign issue_data = (state == STREAM);

    // Tag = {coefficient read, coefficient index}; in_vld marks sample reads only.
    iir_vld_pipe #(
        .DEPTH (RD_LAT + DP_LAT),
        .TAP   (RD_LAT - 1),
        .TAG_W (3)
    ) u_vld_pipe (
        .clk     (clk),
        .rst     (memctl),
        .in_vld  (issue_data),
        .in_tag  ({issue_coef, cidx[1:0]}),
        .tap_vld (tap_vld),
        .tap_tag (tap_tag),
        .out_vld (out_vld)
    );

    assign coef_last = tap_tag[2] && (tap_tag[1:0] == 2'd3);

    // Write path is gated by memctl so an abort suppresses the write in the same cycle.
    assign wr_fire     = out_vld && !memctl && (wr_cnt < NPAIRS);
    assign bus.wr_en   = wr_fire;
    assign bus.wr_data = wr_fire ? {y2k1, y2k} : 16'd0;
    assign dp_en       = (state == STREAM) || (state == DRAIN);
    assign done        = (state == DONE);

    always_ff @(posedge clk) begin
        if (memctl) begin
            state       <= IDLE;
            cidx        <= 3'd0;
            rd_cnt      <= 16'd0;
            wr_cnt      <= 16'd0;
            bus.rd_addr <= 16'd0;
            bus.wr_addr <= 16'd0;
            cycles      <= 16'd0;
            coef_a      <= 8'd0;
            coef_b      <= 8'd0;
            coef_c      <= 8'd0;
            coef_d      <= 8'd0;
            x2k         <= 8'd0;
            x2k1        <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    state       <= COEF;
                    cidx        <= 3'd0;
                    rd_cnt      <= 16'd0;
                    wr_cnt      <= 16'd0;
                    cycles      <= 16'd0;
                    bus.rd_addr <= COEF_BASE;
                    bus.wr_addr <= OUT_BASE;
                end
                COEF: begin
                    if (issue_coef) begin
                        cidx        <= cidx + 3'd1;
                        bus.rd_addr <= bus.rd_addr + 16'd1;
                    end
                    if (coef_last) begin
                        rd_cnt      <= 16'd0;
                        bus.rd_addr <= IN_BASE;
                        state       <= (NPAIRS == 16'd0) ? DONE : STREAM;
                    end
                end
                STREAM: begin
                    cycles <= sat_inc16(cycles);
                    if (rd_cnt == NPAIRS - 16'd1) begin
                        state <= DRAIN;
                    end else begin
                        rd_cnt      <= rd_cnt + 16'd1;
                        bus.rd_addr <= bus.rd_addr + 16'd1;
                    end
                end
                DRAIN: begin
                    cycles <= sat_inc16(cycles);
                    if (wr_fire && (wr_cnt == NPAIRS - 16'd1)) state <= DONE;
                end
                DONE: state <= DONE;
                default: state <= IDLE;
            endcase

            if (wr_fire) begin
                wr_cnt      <= wr_cnt + 16'd1;
                bus.wr_addr <= bus.wr_addr + 16'd1;
            end

            // Read data for the entry at the tap is on rd_data this cycle.
            if (tap_tag[2]) begin
                case (tap_tag[1:0])
                    2'd0: coef_a <= bus.rd_data[7:0];
                    2'd1: coef_b <= bus.rd_data[7:0];
                    2'd2: coef_c <= bus.rd_data[7:0];
                    default: coef_d <= bus.rd_data[7:0];
                endcase
            end
            if (tap_vld) begin
                x2k  <= bus.rd_data[7:0];
                x2k1 <= bus.rd_data[15:8];
            end
        end
    end

endmodule

// File: tb/tb_iir_run_ctrl.sv
// Bench for iir_run_ctrl: three instances (nominal 150 pairs, empty run, saturating run)
// against BRAM models, a y = x+1 datapath stub and a run-level reference model.
module tb_iir_run_ctrl;
    import iir_ctrl_pkg::*;

    localparam int RD_LAT = DEF_RD_LAT;
    localparam int DP_LAT = DEF_DP_LAT;

    logic        clk;
    logic        memctl    [3];
    logic [15:0] rd_addr_o [3];
    logic [15:0] wr_addr_o [3];
    logic [15:0] wr_data_o [3];
    logic [15:0] cycles_o  [3];
    logic        wr_en_o   [3];
    logic        dp_en_o   [3];
    logic        done_o    [3];
    logic [7:0]  ca_o [3], cb_o [3], cc_o [3], cd_o [3], x0_o [3], x1_o [3];

    logic [15:0] imem   [3][65536];
    logic [15:0] omem   [3][65536];
    logic [7:0]  ostamp [3][65536];
    logic [7:0]  run_id [3];
    logic [15:0] rp     [3][RD_LAT];

    int n_cmp = 0;
    int n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : gi
        localparam logic [15:0] NP = (g == 0) ? 16'd150 : (g == 1) ? 16'd0 : 16'hFFFF;
        localparam logic [15:0] OB = (g == 2) ? 16'd0 : 16'd3000;
        iir_run_ctrl_if bus ();
        logic [7:0] y0, y1;
        assign y0 = x0_o[g] + 8'd1;
        assign y1 = x1_o[g] + 8'd1;
        assign bus.rd_data  = rp[g][RD_LAT-1];
        assign rd_addr_o[g] = bus.rd_addr;
        assign wr_addr_o[g] = bus.wr_addr;
        assign wr_data_o[g] = bus.wr_data;
        assign wr_en_o[g]   = bus.wr_en;
        iir_run_ctrl #(
            .COEF_BASE (DEF_COEF_BASE), .IN_BASE (DEF_IN_BASE), .OUT_BASE (OB),
            .NPAIRS (NP), .RD_LAT (RD_LAT), .DP_LAT (DP_LAT)
        ) dut (
            .clk (clk), .memctl (memctl[g]), .bus (bus), .dp_en (dp_en_o[g]),
            .coef_a (ca_o[g]), .coef_b (cb_o[g]), .coef_c (cc_o[g]), .coef_d (cd_o[g]),
            .x2k (x0_o[g]), .x2k1 (x1_o[g]), .y2k (y0), .y2k1 (y1),
            .cycles (cycles_o[g]), .done (done_o[g])
        );
    end

    // BRAM models: registered read with RD_LAT stages, writes stamped with the run id.
    always @(posedge clk) begin
        for (int g = 0; g < 3; g++) begin
            rp[g][0] <= imem[g][rd_addr_o[g]];
            for (int j = 1; j < RD_LAT; j++) rp[g][j] <= rp[g][j-1];
            if (wr_en_o[g]) begin
                omem[g][wr_addr_o[g]]   <= wr_data_o[g];
                ostamp[g][wr_addr_o[g]] <= run_id[g];
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_zero(input int g, input string tag);
        chk({tag, "_words"}, {rd_addr_o[g], wr_addr_o[g], wr_data_o[g], cycles_o[g]}, 64'd0);
        chk({tag, "_bytes"}, {ca_o[g], cb_o[g], cc_o[g], cd_o[g], x0_o[g], x1_o[g],
                              wr_en_o[g], dp_en_o[g], done_o[g]}, 64'd0);
    endtask

    task automatic fill_inputs(input int g, input int np);
        for (int k = 0; k < np; k++) imem[g][16'(DEF_IN_BASE + k)] = 16'($urandom);
    endtask

    // One run from reset release to DONE (or to an abort after abort_at writes).
    task automatic run_inst(input int g, input int np, input logic [15:0] ob, input int abort_at);
        int t, first_dp, rd_bad, dp_bad, nwr, wbad, streak, maxstreak, lat_exp, budget, bad, cyc_exp;
        bit fin;
        logic [15:0] iw;
        logic [7:0] cexp [4];
        for (int i = 0; i < 4; i++) cexp[i] = imem[g][16'(DEF_COEF_BASE + i)][7:0];
        lat_exp = 4 + RD_LAT + 1 + ((np > 0) ? np + RD_LAT + DP_LAT : 0);
        cyc_exp = (np == 0) ? 0 : ((np + RD_LAT + DP_LAT > 65535) ? 65535 : np + RD_LAT + DP_LAT);
        budget  = lat_exp + 50;
        @(posedge clk); #1 memctl[g] = 1'b1;
        repeat (2) @(posedge clk);
        run_id[g] = run_id[g] + 8'd1;
        #1 memctl[g] = 1'b0;
        t = 0; first_dp = -1; rd_bad = 0; dp_bad = 0; nwr = 0; wbad = 0; streak = 0; maxstreak = 0;
        fin = 1'b0;
        while (!fin && t < budget) begin
            @(negedge clk);
            if (done_o[g]) begin
                fin = 1'b1;
            end else begin
                if (dp_en_o[g] && first_dp < 0) begin
                    first_dp = t;
                    chk("coef_at_first_dp", {ca_o[g], cb_o[g], cc_o[g], cd_o[g]},
                        {cexp[0], cexp[1], cexp[2], cexp[3]});
                end
                if (dp_en_o[g] != (first_dp >= 0)) dp_bad++;
                if (first_dp >= 0 && (t - first_dp) < np &&
                    rd_addr_o[g] != 16'(DEF_IN_BASE + t - first_dp)) rd_bad++;
                if (wr_en_o[g]) begin
                    nwr++;
                    streak++;
                    if (streak > maxstreak) maxstreak = streak;
                    if (wr_addr_o[g] != 16'(ob + nwr - 1)) wbad++;
                end else begin
                    streak = 0;
                end
                if (abort_at > 0 && nwr == abort_at) begin
                    @(posedge clk); #1 memctl[g] = 1'b1;
                    @(negedge clk);
                    chk("abort_wr_en_same_cycle", {wr_en_o[g], wr_data_o[g]}, 64'd0);
                    @(negedge clk);
                    chk_zero(g, "abort_outputs");
                    chk("abort_write_addrs", wbad, 0);
                    return;
                end
                t++;
            end
        end
        chk("run_finished", fin, 1);
        chk("done_latency", t, lat_exp);
        chk("first_dp_en", first_dp, (np > 0) ? 4 + RD_LAT + 1 : -1);
        chk("rd_addr_stream", rd_bad, 0);
        chk("dp_en_window", dp_bad, 0);
        chk("write_count", nwr, np);
        chk("write_addrs", wbad, 0);
        chk("write_streak", maxstreak, np);
        chk("cycles_at_done", cycles_o[g], cyc_exp);
        chk("coefs_at_done", {ca_o[g], cb_o[g], cc_o[g], cd_o[g]}, {cexp[0], cexp[1], cexp[2], cexp[3]});
        bad = 0;
        for (int k = 0; k < np; k++) begin
            iw = imem[g][16'(DEF_IN_BASE + k)];
            if (ostamp[g][16'(ob + k)] != run_id[g] ||
                omem[g][16'(ob + k)] != {iw[15:8] + 8'd1, iw[7:0] + 8'd1}) bad++;
        end
        chk("out_words", bad, 0);
        repeat (3) @(negedge clk);
        chk("hold_done", done_o[g], 1);
        chk("hold_no_write", {wr_en_o[g], dp_en_o[g]}, 0);
        chk("hold_cycles", cycles_o[g], cyc_exp);
    endtask

    initial begin
        for (int g = 0; g < 3; g++) begin
            memctl[g] = 1'b1;
            run_id[g] = 8'd0;
        end
        for (int i = 0; i < 4; i++) begin
            imem[0][i] = 16'(i + 1);
            imem[1][i] = 16'($urandom);
        end
        fill_inputs(0, 150);
        imem[0][16'd2000] = 16'h0A05;
        for (int a = 0; a < 65536; a++) imem[2][a] = 16'($urandom);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero(0, "reset");
        chk_zero(2, "reset_sat");

        run_inst(0, 150, 16'd3000, 0);
        chk("word_3000", omem[0][16'd3000], 16'h0B06);

        fill_inputs(0, 150);
        run_inst(0, 150, 16'd3000, 50);

        for (int i = 0; i < 4; i++) imem[0][i] = 16'($urandom);
        fill_inputs(0, 150);
        run_inst(0, 150, 16'd3000, 0);

        run_inst(1, 0, 16'd3000, 0);
        run_inst(2, 65535, 16'd0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/iir_run_ctrl.md
IIR_RUN_CTRL -- requirements
Module: iir_run_ctrl

Interface
REQ-001 Parameters SHALL be as follows, one per line: name, default, meaning.
- COEF_BASE, 16'd0, word address of coefficient a; b, c, d follow at +1, +2, +3.
- IN_BASE, 16'd2000, first packed input word (x2k in [7:0], x2k1 in [15:8]).
- OUT_BASE, 16'd3000, first packed output word (y2k in [7:0], y2k1 in [15:8]).
- NPAIRS, 16'd150, number of sample pairs per run.
- RD_LAT, 2, BRAM read latency in cycles.
- DP_LAT, 1, datapath latency in cycles, from x registered to y valid.

REQ-002 Ports SHALL be as follows, one per line: name, direction, width, meaning.
- clk, in, 1, the single clock; all logic is on posedge.
- memctl, in, 1, reset: synchronous, active-high; while high the block is held in reset.
- rd_addr, out, 16, BRAM read-port address.
- rd_data, in, 16, BRAM read data, valid RD_LAT cycles after its address.
- wr_en, out, 1, BRAM write-port enable.
- wr_addr, out, 16, BRAM write-port address.
- wr_data, out, 16, BRAM write-port data.
- dp_en, out, 1, datapath enable, high in STREAM and DRAIN.
- coef_a, coef_b, coef_c, coef_d, out, 8 each, datapath coefficients.
- x2k, x2k1, out, 8 each, datapath inputs.
- y2k, y2k1, in, 8 each, datapath outputs.
- cycles, out, 16, run length counter.
- done, out, 1, run complete.

Function
REQ-003 The FSM SHALL have exactly these states: IDLE, COEF, STREAM, DRAIN, DONE.
REQ-004 IDLE SHALL move to COEF on the first clock edge with memctl low.
REQ-005 COEF SHALL issue rd_addr = COEF_BASE+0..3 on four consecutive cycles.
- coef_a..d SHALL load rd_data[7:0] exactly RD_LAT cycles after each address is issued.
- The FSM SHALL move to STREAM the cycle after coef_d loads.
REQ-006 STREAM SHALL issue rd_addr = IN_BASE+k, k = 0..NPAIRS-1, one per cycle with no bubbles, and SHALL move to DRAIN after issuing the last address.
REQ-007 A valid shift register of depth RD_LAT+DP_LAT SHALL track every issued input address.
- x2k/x2k1 SHALL load rd_data[7:0]/[15:8] RD_LAT cycles after issue.
- wr_en SHALL be high DP_LAT cycles after that, with wr_data = {y2k1, y2k}.
REQ-008 wr_addr SHALL equal OUT_BASE+k for the k-th write.
- wr_addr SHALL increment only after a write.
- No write SHALL occur outside the range OUT_BASE..OUT_BASE+NPAIRS-1.
REQ-009 DRAIN SHALL move to DONE in the cycle the NPAIRS-th write is performed.
REQ-010 cycles SHALL increment once per cycle in STREAM and DRAIN and SHALL saturate at 16'hFFFF; it SHALL hold its value in DONE.
REQ-011 In DONE, done SHALL be 1, wr_en SHALL be 0, and the state SHALL be held until memctl is asserted.
REQ-012 With NPAIRS = 0 the FSM SHALL go from COEF straight to DONE; there SHALL be no writes and cycles SHALL stay 0.
REQ-013 dp_en SHALL be 0 in IDLE, COEF and DONE.
REQ-014 Total latency from entering STREAM to entering DONE SHALL be NPAIRS+RD_LAT+DP_LAT cycles.

Reset
REQ-015 With memctl high at a clock edge, the following SHALL hold on the next cycle:
- state = IDLE;
- all outputs = 0, including coef_*, x2k*, cycles, done, wr_en, rd_addr, wr_addr;
- the valid pipe is cleared.
REQ-016 memctl asserted mid-run SHALL abort the run within one cycle and no further write SHALL occur; the next deassertion SHALL start a fresh run from COEF.

Structure
REQ-017 The state enum, default base addresses and the latency constants SHALL live in package iir_ctrl_pkg.
REQ-018 The valid/index delay line SHALL be one sub-module, iir_vld_pipe, with parameter DEPTH = RD_LAT+DP_LAT.

Verification
REQ-019 Nominal run: BRAM model with coef = 1, 2, 3, 4 and NPAIRS = 150 -> coef_a..d = 1..4 before the first dp_en; 150 writes at 3000..3149; done asserts with cycles = 153.
REQ-020 Write-data check: input word 16'h0A05 at 2000 with a datapath stub y = x+1 -> word 3000 = 16'h0B06.
REQ-021 Empty run: NPAIRS = 0 -> done 4+RD_LAT+1 cycles after memctl falls; zero writes; cycles = 0.
REQ-022 Abort: memctl raised after the 50th write -> wr_en = 0 from the next cycle and all outputs are 0; a rerun rewrites 3000..3149 completely.
REQ-023 Saturation: NPAIRS = 16'hFFFF with OUT_BASE = 0 -> cycles holds at 16'hFFFF and done still asserts.
REQ-024 Bubble-free stream: check that rd_addr increments every cycle in STREAM and that wr_en stays high for NPAIRS consecutive cycles.
